// File: rtl/factorial_inverse.sv
// rtl/factorial_inverse.sv - iterative inverse factorial: largest n with n! <= value
module factorial_inverse (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic [3:0]  n,
  output logic [31:0] fact,
  output logic        exact,
  output logic        none
);

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  state_t      state, state_nx;
  logic [31:0] val_r;
  logic [31:0] acc;
  logic [3:0]  k;
  logic [3:0]  k_inc;
  logic [35:0] prod;
  logic        fits;

  // Full 36-bit product so 12! * 13 cannot wrap into a false "fits".
  assign k_inc = k + 4'd1;
  assign prod  = {4'b0, acc} * {32'b0, k_inc};
  assign fits  = (prod <= {4'b0, val_r});

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = (value == 32'd0) ? DONE : STEP;
      end
      STEP: begin
        if (!fits) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_r <= 32'd0;
      acc   <= 32'd0;
      k     <= 4'd0;
      n     <= 4'd0;
      fact  <= 32'd0;
      exact <= 1'b0;
      none  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            val_r <= value;
            if (value == 32'd0) begin
              n     <= 4'd0;
              fact  <= 32'd0;
              exact <= 1'b0;
              none  <= 1'b1;
            end else begin
              acc <= 32'd1;
              k   <= 4'd1;
            end
          end
        end
        STEP: begin
          if (fits) begin
            acc <= prod[31:0];
            k   <= k_inc;
          end else begin
            n     <= k;
            fact  <= acc;
            exact <= (acc == val_r);
            none  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_factorial_inverse.sv
// tb/tb_factorial_inverse.sv - directed self-checking bench for factorial_inverse
module tb_factorial_inverse;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic [3:0]  n;
  logic [31:0] fact;
  logic        exact;
  logic        none;

  int errors = 0;
  int checks = 0;

  factorial_inverse dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .value(value),
    .busy (busy),
    .done (done),
    .n    (n),
    .fact (fact),
    .exact(exact),
    .none (none)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [3:0] en, input logic [31:0] ef,
                             input logic ee, input logic eo);
    chk({tag, ".n"},     {28'd0, n},     {28'd0, en});
    chk({tag, ".fact"},  fact,           ef);
    chk({tag, ".exact"}, {31'd0, exact}, {31'd0, ee});
    chk({tag, ".none"},  {31'd0, none},  {31'd0, eo});
  endtask

  // One request from IDLE; checks latency, busy length, results and return to idle.
  task automatic run(input string tag, input logic [31:0] v, input logic [3:0] en,
                     input logic [31:0] ef, input logic ee, input logic eo);
    int lat;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    value = v;
    @(negedge clk);
    start = 1'b0;
    value = 32'hDEAD_BEEF;
    lat = 0;
    busy_cnt = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
      else begin
        lat++;
        @(negedge clk);
      end
    end
    chk({tag, ".done_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, ".latency"}, lat, {28'd0, en});
    chk({tag, ".busy_cycles"}, busy_cnt, {28'd0, en} + 32'd1);
    chk_outputs(tag, en, ef, ee, eo);
    @(negedge clk);
    chk({tag, ".idle_done"}, {31'd0, done}, 32'd0);
    chk({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
    chk_outputs({tag, ".hold"}, en, ef, ee, eo);
  endtask

  initial begin
    int pulses;
    int first;
    rst   = 1'b1;
    start = 1'b1;
    value = 32'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.done", {31'd0, done}, 32'd0);
    chk_outputs("reset", 4'd0, 32'd0, 1'b0, 1'b0);
    rst   = 1'b0;
    start = 1'b0;

    run("v120",  32'd120,       4'd5,  32'd120,       1'b1, 1'b0);
    run("v100",  32'd100,       4'd4,  32'd24,        1'b0, 1'b0);
    run("v0",    32'd0,         4'd0,  32'd0,         1'b0, 1'b1);
    run("v1",    32'd1,         4'd1,  32'd1,         1'b1, 1'b0);
    run("v12f",  32'd479001600, 4'd12, 32'd479001600, 1'b1, 1'b0);
    run("vmax",  32'hFFFF_FFFF, 4'd12, 32'd479001600, 1'b0, 1'b0);

    // Start while busy must be ignored: one done pulse, 720 result.
    @(negedge clk);
    start = 1'b1;
    value = 32'd720;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    value = 32'd2;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    first  = -1;
    for (int c = 2; c < 20; c++) begin
      if (done) begin
        pulses++;
        if (first < 0) first = c;
      end
      @(negedge clk);
    end
    chk("busy_start.pulses", pulses, 32'd1);
    chk("busy_start.latency", first, 32'd6);
    chk_outputs("busy_start", 4'd6, 32'd720, 1'b1, 1'b0);

    // Reset after three STEP cycles: IDLE, outputs zeroed, no done.
    @(negedge clk);
    start = 1'b1;
    value = 32'd5040;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.busy", {31'd0, busy}, 32'd0);
    chk_outputs("midrst", 4'd0, 32'd0, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    chk("midrst.no_done", pulses, 32'd0);
    run("v6",    32'd6,         4'd3,  32'd6,         1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/factorial_inverse.md
# factorial_inverse

Iterative inverse-factorial engine that pairs with the team's factorial calculator. Given a 32-bit value, it finds the largest n with n! ≤ value, returns that n and n!, and flags whether the value is an exact factorial. It sits on the keypad/VGA text datapath as a sequential co-processor: the host pulses start, waits for done, and reads the results.

## Interface
- No parameters. Widths are fixed: value and fact are 32 bits, n is 4 bits. The maximum result is 12, because 12! = 479001600 fits in 32 bits and 13! does not.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- value  input  32  unsigned operand; captured on the edge that accepts start.
- busy  output  1  high while the request is in progress; equals (state != IDLE).
- done  output  1  high for exactly one cycle, while state == DONE.
- n  output  4  largest n with n! ≤ value; 0 when value == 0.
- fact  output  32  n!; 0 when value == 0.
- exact  output  1  high when fact == captured value.
- none  output  1  high when value == 0, since no factorial is ≤ 0.

## Operation
- Internal registers:
  - val_r: 32 bits, captured operand.
  - acc: 32 bits, running factorial.
  - k: 4 bits, current index.
  - state: one of IDLE, STEP, DONE.
- IDLE
  - busy = 0.
  - On start = 1: capture val_r = value.
  - If value == 0, go to DONE with n = 0, fact = 0, exact = 0, none = 1.
  - Otherwise set acc = 1, k = 1, and go to STEP.
  - start = 0: stay in IDLE.
- STEP: one compare/multiply per cycle.
  - prod = acc × (k+1), computed 36 bits wide (32 × 4), with val_r zero-extended to 36 bits for the compare. Truncating prod to 32 bits is not allowed.
  - If prod ≤ val_r: acc = prod[31:0], k = k+1, stay in STEP.
  - Else: go to DONE, loading n = k, fact = acc, exact = (acc == val_r), none = 0.
- DONE
  - done = 1 and busy = 1.
  - Always return to IDLE on the next edge.
- n, fact, exact, and none are registered.
  - They change only on entry to DONE or on rst.
  - They hold their values through IDLE until the next result loads.
- start while busy (STEP or DONE) is ignored and never queued. value is don't-care outside IDLE.
- start held high continuously: a new request is accepted on each IDLE cycle, i.e. every other cycle after DONE.
- k can never exceed 12, because 13! exceeds any 32-bit val_r. The 4-bit width is sufficient, with no wrap.

## Timing
- Reset
  - On the edge with rst = 1: state = IDLE; busy, done, n, fact, exact, none all 0; acc = 0, k = 0, val_r = 0.
  - rst has priority over start and over every state transition.
- Reset mid-operation (STEP or DONE): go to IDLE on that edge. No done pulse is produced and the outputs are zeroed.
- Latency, with start accepted at edge E:
  - done is high during the cycle following edge E + n, where n is the final result (n = 0 when value == 0).
  - The STEP cycle count is n: n−1 successful multiplies plus 1 failing compare.
  - Worst case is value ≥ 12!: done after edge E+12.
- busy rises after edge E and falls after the edge that exits DONE.
- The next start can be accepted on the first IDLE edge after DONE. Minimum request spacing is n+2 cycles.
- Single-cycle paths: a 32×4 multiply plus a 36-bit compare per cycle. No multi-cycle paths are allowed.

## Test plan
- value = 120, start for 1 cycle → done after edge E+5; n = 5, fact = 120, exact = 1, none = 0; busy high for 6 cycles.
- value = 100 → n = 4, fact = 24, exact = 0, none = 0; done after edge E+4.
- value = 0 → done after edge E; n = 0, fact = 0, exact = 0, none = 1. Then value = 1 → n = 1, fact = 1, exact = 1.
- value = 479001600 → n = 12, fact = 479001600, exact = 1. Then value = 0xFFFFFFFF → n = 12, fact = 479001600, exact = 0; checks no 13× overflow wrap.
- Start value = 720; pulse start again with value = 2 during STEP → second request ignored; n = 6, fact = 720, exact = 1; exactly one done pulse.
- Start value = 5040; assert rst for 1 cycle after 3 STEP cycles → IDLE on that edge; all outputs 0; no done. Then a new start with value = 6 → n = 3, fact = 6, exact = 1.
